// File: rtl/load_store_unit_if.sv
// Execute-stage request, write-back result and external memory bus of the load/store unit.
// The master modport is the unit's view; slave is the pipeline/memory-controller side.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_req_valid;
  logic                  i_req_wr;
  logic [2:0]            i_funct3;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_stall;
  logic                  o_done;
  logic                  o_rd_valid;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_exc;
  logic [1:0]            o_exc_cause;
  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [3:0]            o_mem_be;
  logic                  i_mem_ready;
  logic                  i_mem_rvalid;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  modport master (
    input  i_req_valid, i_req_wr, i_funct3, i_addr, i_wr_data,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_stall, o_done, o_rd_valid, o_rd_data, o_exc, o_exc_cause,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
  );

  modport slave (
    output i_req_valid, i_req_wr, i_funct3, i_addr, i_wr_data,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_stall, o_done, o_rd_valid, o_rd_data, o_exc, o_exc_cause,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns execute-stage loads/stores into word-aligned
// valid/ready bus transactions, formats load data and raises alignment/funct3/timeout exceptions.
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               i_clk,
  input logic               i_reset,
  load_store_unit_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RD_WAIT} state_t;

  state_t                state_q;
  logic                  mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q, rd_data_q;
  logic [3:0]            mem_be_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic                  done_q, rd_valid_q, exc_q;
  logic [1:0]            exc_cause_q;
  logic [CNT_W-1:0]      tmo_q;

  function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
    if (wr) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return ~off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_lanes(input logic [2:0] f3,
                                                         input logic [DATA_WIDTH-1:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Lane selection uses the byte offset latched at acceptance, not the live address.
  function automatic logic [DATA_WIDTH-1:0] load_format(input logic [2:0] f3,
                                                         input logic [1:0] off,
                                                         input logic [DATA_WIDTH-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  return {{(DATA_WIDTH-16){h[15]}}, h};
      3'b100:  return {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  return {{(DATA_WIDTH-16){1'b0}}, h};
      default: return d;
    endcase
  endfunction

  logic legal, aligned, accept, reject, tmo_hit;

  assign legal   = f3_legal(bus.i_req_wr, bus.i_funct3);
  assign aligned = is_aligned(bus.i_funct3, bus.i_addr[1:0]);
  assign accept  = (state_q == S_IDLE) && bus.i_req_valid && legal && aligned;
  assign reject  = (state_q == S_IDLE) && bus.i_req_valid && !(legal && aligned);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

  assign bus.o_stall     = accept || (state_q != S_IDLE);
  assign bus.o_done      = done_q;
  assign bus.o_rd_valid  = rd_valid_q;
  assign bus.o_rd_data   = rd_data_q;
  assign bus.o_exc       = exc_q;
  assign bus.o_exc_cause = exc_cause_q;
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_be    = mem_be_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      exc_q       <= 1'b0;
      exc_cause_q <= 2'b00;
      tmo_q       <= '0;
    end else begin
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      exc_q       <= 1'b0;
      exc_cause_q <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q     <= S_REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.i_req_wr;
            mem_addr_q  <= {bus.i_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_q <= store_lanes(bus.i_funct3, bus.i_wr_data);
            mem_be_q    <= bus.i_req_wr ? store_be(bus.i_funct3, bus.i_addr[1:0]) : 4'b1111;
            funct3_q    <= bus.i_funct3;
            off_q       <= bus.i_addr[1:0];
            tmo_q       <= '0;
          end else if (reject) begin
            exc_q       <= 1'b1;
            exc_cause_q <= legal ? 2'b01 : 2'b10;
          end
        end
        S_REQ: begin
          if (bus.i_mem_ready) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else if (bus.i_mem_rvalid) begin
              rd_data_q  <= load_format(funct3_q, off_q, bus.i_mem_rdata);
              rd_valid_q <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              state_q <= S_RD_WAIT;
              if (!tmo_hit) tmo_q <= tmo_q + 1'b1;
            end
          end else if (tmo_hit) begin
            mem_req_q   <= 1'b0;
            exc_q       <= 1'b1;
            exc_cause_q <= 2'b11;
            state_q     <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (bus.i_mem_rvalid) begin
            rd_data_q  <= load_format(funct3_q, off_q, bus.i_mem_rdata);
            rd_valid_q <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= S_IDLE;
          end else if (tmo_hit) begin
            exc_q       <= 1'b1;
            exc_cause_q <= 2'b11;
            state_q     <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random loads/stores against a behavioural model,
// with a second instance using a short bus timeout.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr_in = '0, wr_data = '0;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_asrt = 0;
  int n_fail = 0;
  logic [31:0] m_rd = '0;

  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifa ();
  load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ift ();

  assign ifa.i_req_valid  = req_valid;
  assign ifa.i_req_wr     = req_wr;
  assign ifa.i_funct3     = funct3;
  assign ifa.i_addr       = addr_in;
  assign ifa.i_wr_data    = wr_data;
  assign ifa.i_mem_ready  = mem_ready;
  assign ifa.i_mem_rvalid = mem_rvalid;
  assign ifa.i_mem_rdata  = mem_rdata;
  assign ift.i_req_valid  = req_valid;
  assign ift.i_req_wr     = req_wr;
  assign ift.i_funct3     = funct3;
  assign ift.i_addr       = addr_in;
  assign ift.i_wr_data    = wr_data;
  assign ift.i_mem_ready  = mem_ready;
  assign ift.i_mem_rvalid = mem_rvalid;
  assign ift.i_mem_rdata  = mem_rdata;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(ifa));
  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut_t (
    .i_clk(clk), .i_reset(rst), .bus(ift));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected write-back value straight from the RISC-V load rules.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    int unsigned       sh;
    logic [31:0]       v;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    sh  = f3[0] ? (int'(off) & 2) : int'(off);
    v   = rdata >> (8 * sh);
    sb  = v[7:0];
    shw = v[15:0];
    case (f3)
      3'b000:  return 32'(int'(sb));
      3'b001:  return 32'(int'(shw));
      3'b100:  return {24'h0, v[7:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return rdata;
    endcase
  endfunction

  task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int rdy_dly, input int rv_dly, input string tag);
    logic       legal, aligned;
    logic [3:0] be;
    logic [31:0] wd;
    int          fin;
    legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    case (f3[1:0])
      2'd1:    aligned = !addr[0];
      2'd2:    aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    case (f3[1:0])
      2'd0:    begin be = 4'b0001 << addr[1:0]; wd = {4{wdata[7:0]}}; end
      2'd1:    begin be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{wdata[15:0]}}; end
      default: begin be = 4'b1111; wd = wdata; end
    endcase
    if (!wr) be = 4'b1111;

    req_valid = 1'b1; req_wr = wr; funct3 = f3; addr_in = addr; wr_data = wdata;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk({tag, ":stall_accept"}, ifa.o_stall, legal && aligned);
    @(posedge clk); #1;
    req_valid = 1'b0;

    if (!(legal && aligned)) begin
      chk({tag, ":exc"}, ifa.o_exc, 1);
      chk({tag, ":cause"}, ifa.o_exc_cause, legal ? 2'b01 : 2'b10);
      chk({tag, ":no_req"}, ifa.o_mem_req, 0);
      chk({tag, ":no_done"}, ifa.o_done, 0);
      chk({tag, ":rd_hold"}, ifa.o_rd_data, m_rd);
      @(posedge clk); #1;
      chk({tag, ":exc_pulse"}, ifa.o_exc, 0);
      return;
    end

    fin = wr ? rdy_dly : rdy_dly + rv_dly;
    for (int k = 0; k <= fin; k++) begin
      mem_ready  = (k >= rdy_dly);
      mem_rvalid = wr ? 1'($urandom_range(0, 1)) : (k == fin);
      mem_rdata  = (wr || k != fin) ? $urandom : rdata;
      #1;
      chk({tag, ":stall_busy"}, ifa.o_stall, 1);
      chk({tag, ":req"}, ifa.o_mem_req, k <= rdy_dly);
      chk({tag, ":done_early"}, ifa.o_done, 0);
      if (k <= rdy_dly) begin
        chk({tag, ":addr"}, ifa.o_mem_addr, {addr[31:2], 2'b00});
        chk({tag, ":be"}, ifa.o_mem_be, be);
        chk({tag, ":we"}, ifa.o_mem_we, wr);
        if (wr) chk({tag, ":wdata"}, ifa.o_mem_wdata, wd);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    if (!wr) m_rd = model_load(f3, addr[1:0], rdata);
    #1;
    chk({tag, ":done"}, ifa.o_done, 1);
    chk({tag, ":rd_valid"}, ifa.o_rd_valid, !wr);
    chk({tag, ":rd_data"}, ifa.o_rd_data, m_rd);
    chk({tag, ":stall_done"}, ifa.o_stall, 0);
    chk({tag, ":exc_none"}, ifa.o_exc, 0);
    chk({tag, ":req_off"}, ifa.o_mem_req, 0);
    @(posedge clk); #1;
    chk({tag, ":done_pulse"}, ifa.o_done, 0);
    chk({tag, ":rdv_pulse"}, ifa.o_rd_valid, 0);
  endtask

  initial begin
    logic        r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [2:0]  legal_ld [5];
    legal_ld[0] = 3'b000; legal_ld[1] = 3'b001; legal_ld[2] = 3'b010;
    legal_ld[3] = 3'b100; legal_ld[4] = 3'b101;

    repeat (2) @(posedge clk);
    #1;
    chk("rst:req", ifa.o_mem_req, 0);
    chk("rst:stall", ifa.o_stall, 0);
    chk("rst:done", ifa.o_done, 0);
    chk("rst:rdv", ifa.o_rd_valid, 0);
    chk("rst:rd", ifa.o_rd_data, 0);
    chk("rst:exc", ifa.o_exc, 0);
    chk("rst:be", ifa.o_mem_be, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, "sb");
    run_op(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 0, "lb");
    run_op(1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 0, "lbu");
    run_op(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 3, 5, "lh_wait");
    run_op(1'b0, 3'b010, 32'h0000_2002, 32'h0, 32'h0, 0, 0, "lw_misal");
    run_op(1'b0, 3'b011, 32'h0000_2000, 32'h0, 32'h0, 0, 0, "f3_011");
    run_op(1'b1, 3'b001, 32'h0000_2006, 32'hDEAD_BEEF, 32'h0, 1, 0, "sh_hi");
    run_op(1'b1, 3'b100, 32'h0000_2003, 32'h0, 32'h0, 0, 0, "st_ill_misal");
    run_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hF00D_1234, 2, 0, "lhu");

    for (int i = 0; i < 40; i++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 32'h0000_5000 + ($urandom & 32'hFF);
      if ($urandom_range(0, 4) == 0) r_f3 = 3'($urandom_range(0, 7));
      else if (r_wr) r_f3 = 3'($urandom_range(0, 2));
      else r_f3 = legal_ld[$urandom_range(0, 4)];
      run_op(r_wr, r_f3, r_addr, $urandom, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), "rand");
    end

    // Back-to-back: a new request presented in the o_done cycle of a store.
    req_valid = 1'b1; req_wr = 1'b1; funct3 = 3'b010; addr_in = 32'h4000; wr_data = 32'h1234_5678;
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; funct3 = 3'b010; addr_in = 32'h4004;
    #1;
    chk("b2b:done", ifa.o_done, 1);
    chk("b2b:stall", ifa.o_stall, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
    #1;
    chk("b2b:req", ifa.o_mem_req, 1);
    chk("b2b:addr", ifa.o_mem_addr, 32'h4004);
    chk("b2b:we", ifa.o_mem_we, 0);
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    m_rd = 32'hCAFE_0001;
    chk("b2b:rdv", ifa.o_rd_valid, 1);
    chk("b2b:rd", ifa.o_rd_data, m_rd);

    // Timeout on the short-timeout instance, after a synchronising reset and one load.
    rst = 1'b1; #2; rst = 1'b0; m_rd = '0;
    @(posedge clk); #1;
    run_op(1'b0, 3'b010, 32'h0000_3010, 32'h0, 32'h7777_AAAA, 1, 1, "tmo_pre");
    chk("tmo:pre_rd", ift.o_rd_data, m_rd);
    req_valid = 1'b1; req_wr = 1'b0; funct3 = 3'b010; addr_in = 32'h3000;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk("tmo:stall_acc", ift.o_stall, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("tmo:req_held", ift.o_mem_req, 1);
      chk("tmo:no_exc", ift.o_exc, 0);
      @(posedge clk); #1;
    end
    chk("tmo:req_drop", ift.o_mem_req, 0);
    chk("tmo:exc", ift.o_exc, 1);
    chk("tmo:cause", ift.o_exc_cause, 2'b11);
    chk("tmo:no_done", ift.o_done, 0);
    chk("tmo:rd_hold", ift.o_rd_data, m_rd);
    req_valid = 1'b1; req_wr = 1'b1; funct3 = 3'b010; addr_in = 32'h3004; wr_data = 32'h0BAD_F00D;
    mem_ready = 1'b1;
    #1;
    chk("tmo:next_stall", ift.o_stall, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("tmo:next_req", ift.o_mem_req, 1);
    chk("tmo:next_addr", ift.o_mem_addr, 32'h3004);
    chk("tmo:exc_pulse", ift.o_exc, 0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("tmo:next_done", ift.o_done, 1);

    // Reset while a load waits in RD_WAIT; a late rvalid must not complete it.
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 3'b010, 32'h0000_6100, 32'h0, 32'h5555_0000, 0, 0, "rst_pre");
    req_valid = 1'b1; req_wr = 1'b0; funct3 = 3'b010; addr_in = 32'h6000;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    chk("rstw:stall", ifa.o_stall, 1);
    rst = 1'b1;
    #1;
    chk("rstw:stall0", ifa.o_stall, 0);
    chk("rstw:req0", ifa.o_mem_req, 0);
    chk("rstw:rd0", ifa.o_rd_data, 0);
    chk("rstw:done0", ifa.o_done, 0);
    chk("rstw:exc0", ifa.o_exc, 0);
    chk("rstw:be0", ifa.o_mem_be, 0);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("rstw:late_rdv", ifa.o_rd_valid, 0);
    chk("rstw:late_done", ifa.o_done, 0);
    @(posedge clk); #1;
    chk("rstw:late_rdv2", ifa.o_rd_valid, 0);
    chk("rstw:late_rd", ifa.o_rd_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
